// File: rtl/disp_pkg.sv
// disp_pkg: shared types and glyph/anode constants for the 4-digit 7-segment scanner.
package disp_pkg;
  typedef logic [1:0] digit_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
  // Active-low segments, bit 6 = a ... bit 0 = g, indexed by nibble value 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic logic [3:0] an_code(input digit_t d);
    return d == 2'd0 ? AN_D0 : d == 2'd1 ? AN_D1 : d == 2'd2 ? AN_D2 : AN_D3;
  endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low 7-segment glyph decoder.
// Ports: nib_i nibble in, seg_o active-low segments (bit 6 = a ... bit 0 = g).
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_HEX[nib_i];
endmodule

// File: rtl/disp_scan.sv
// disp_scan: frame-latched 4-digit 7-segment scanner showing sel, blank, y[3:0], y[7:4].
// Ports: clk, reset (sync, active-high), y/sel data, hold (freeze shadows at frame start),
// anode/seg active-low registered pins, digit slot index, frame_start one-cycle pulse.
// Optional anti-ghosting gap at the start of each slot: define DISP_SCAN_BLANK_EN.
module disp_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] y,
  input  logic [3:0] sel,
  input  logic       hold,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic [1:0] digit,
  output logic       frame_start
);
`ifdef DISP_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  digit_t digit_q, digit_d;
  logic [7:0] sh_y_q, sh_y_d;
  logic [3:0] sh_sel_q, sh_sel_d;
  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic fs, wrap, blank;
  always_comb begin
    wrap = cnt_q == CW'(REFRESH_DIV - 1);
    fs = cnt_q == '0 && digit_q == 2'd0;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    digit_d = wrap ? digit_q + 1'b1 : digit_q;
    sh_y_d = fs && !hold ? y : sh_y_q;
    sh_sel_d = fs && !hold ? sel : sh_sel_q;
    // Digit 0 decodes the value being captured this cycle so the first glyph of a frame is fresh.
    nib = digit_q == 2'd0 ? sh_sel_d : digit_q == 2'd2 ? sh_y_q[3:0] : sh_y_q[7:4];
    blank = BLANK_EN && cnt_q < CW'(BLANK_CYC);
    anode_d = blank ? AN_OFF : an_code(digit_q);
    seg_d = blank || digit_q == 2'd1 ? SEG_BLANK : glyph;
  end
  hex_to_seg u_hex (.nib_i(nib), .seg_o(glyph));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      digit_q <= 2'd0;
      sh_y_q <= '0;
      sh_sel_q <= '0;
      anode_q <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      digit_q <= digit_d;
      sh_y_q <= sh_y_d;
      sh_sel_q <= sh_sel_d;
      anode_q <= anode_d;
      seg_q <= seg_d;
    end
  end
  assign anode = anode_q;
  assign seg = seg_q;
  assign digit = digit_q;
  assign frame_start = fs && !reset;
endmodule
